// File: rtl/cpu_pkg.sv
// Shared CPU types: PC/instruction types, fetch FSM states, opcode constants.
package cpu_pkg;

   localparam int CPU_PC_W   = 8;
   localparam int CPU_INST_W = 16;

   typedef logic [CPU_PC_W-1:0]   pc_t;
   typedef logic [CPU_INST_W-1:0] inst_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DRAIN
   } if_state_e;

   localparam logic [2:0] OPC_JAL = 3'b011;

endpackage

// File: rtl/if_pc_gen.sv
// PC register with next-PC mux (hold / +1 / redirect).
// Latency: new PC visible the cycle after inc_en or redirect_en.
// Backpressure: none; the caller decides when to advance.
module if_pc_gen
   import cpu_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inc_en,
   input  logic            redirect_en,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [PC_W-1:0] pc
);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redirect_en) begin
         pc <= redirect_pc;
      end else if (inc_en) begin
         // Wraps naturally mod 2^PC_W.
         pc <= pc + PC_W'(1);
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, fetches over req/gnt/rvalid, hands one instruction to ID.
// Latency: grant in cycle N, rvalid earliest N+1, if_valid the cycle after rvalid (>= 2 cycles/inst).
// Backpressure: no request while the output holds an unconsumed instruction. IF_PERF_CNT_EN adds perf counters.
module if_stage
   import cpu_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              INST_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic              im_req,
   output logic [PC_W-1:0]   im_addr,
   input  logic              im_gnt,
   input  logic              im_rvalid,
   input  logic [INST_W-1:0] im_rdata,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   input  logic              id_ready,
   output logic              if_valid,
   output logic [INST_W-1:0] if_inst,
   output logic [PC_W-1:0]   if_pc,
   output logic [PC_W-1:0]   if_pc_plus1
`ifdef IF_PERF_CNT_EN
   ,
   output logic [15:0]       perf_fetch_cnt,
   output logic [15:0]       perf_flush_cnt
`endif
);

   if_state_e         state_q, state_d;
   logic [PC_W-1:0]   pc;
   logic [INST_W-1:0] inst_q;
   logic              redir;
   logic              grant;
   logic              capture;
   logic              consume;

   assign redir   = redirect_valid && (state_q != IDLE);
   assign im_req  = (state_q == REQ) && (!if_valid || id_ready);
   assign im_addr = im_req ? pc : '0;
   assign grant   = im_req && im_gnt;
   assign capture = (state_q == WAIT) && im_rvalid && !redir;
   assign consume = if_valid && id_ready;

   if_pc_gen #(
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC)
   ) u_pc_gen (
      .clk         (clk),
      .rst         (rst),
      .inc_en      (capture),
      .redirect_en (redir),
      .redirect_pc (redirect_pc),
      .pc          (pc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A redirect either drops data landing now, or leaves a response in flight to drain.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  state_d = REQ;
         REQ: begin
            if (redir)      state_d = grant ? DRAIN : REQ;
            else if (grant) state_d = WAIT;
         end
         WAIT: begin
            if (redir)          state_d = im_rvalid ? REQ : DRAIN;
            else if (im_rvalid) state_d = REQ;
         end
         DRAIN: begin
            if (!redir && im_rvalid) state_d = REQ;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if_valid <= 1'b0;
         inst_q   <= '0;
         if_pc    <= '0;
      end else if (redir) begin
         if_valid <= 1'b0;
      end else if (capture) begin
         if_valid <= 1'b1;
         inst_q   <= im_rdata;
         if_pc    <= pc;
      end else if (consume) begin
         if_valid <= 1'b0;
      end
   end

   assign if_inst     = if_valid ? inst_q : '0;
   assign if_pc_plus1 = if_pc + PC_W'(1);

`ifdef IF_PERF_CNT_EN
   logic flush_evt;

   // A redirect in DRAIN drops nothing new; the in-flight fetch was already counted.
   assign flush_evt = redir && (if_valid || (state_q == WAIT) || grant);

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (consume && (perf_fetch_cnt != 16'hFFFF)) perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
         if (flush_evt && (perf_flush_cnt != 16'hFFFF)) perf_flush_cnt <= perf_flush_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed fetch/backpressure/redirect/wrap/reset sequences.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        im_req;
   logic [7:0]  im_addr;
   logic        im_gnt;
   logic        im_rvalid;
   logic [15:0] im_rdata;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        id_ready;
   logic        if_valid;
   logic [15:0] if_inst;
   logic [7:0]  if_pc;
   logic [7:0]  if_pc_plus1;
`ifdef IF_PERF_CNT_EN
   logic [15:0] perf_fetch_cnt;
   logic [15:0] perf_flush_cnt;
`endif

   typedef struct {
      logic [7:0]  pc;
      logic [15:0] inst;
   } exp_t;

   exp_t sb[$];
   int   pop_cyc[$];
   int   n_cmp    = 0;
   int   n_err    = 0;
   int   cyc      = 0;
   int   rv_delay = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   if_stage #(.PC_W(8), .RESET_PC(8'h00), .INST_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .im_req         (im_req),
      .im_addr        (im_addr),
      .im_gnt         (im_gnt),
      .im_rvalid      (im_rvalid),
      .im_rdata       (im_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_inst        (if_inst),
      .if_pc          (if_pc),
      .if_pc_plus1    (if_pc_plus1)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   function automatic logic [15:0] mem(input logic [7:0] a);
      return {8'h20, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] a);
      exp_t e;
      e.pc   = a;
      e.inst = mem(a);
      sb.push_back(e);
   endtask

   task automatic wait_empty(input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin
         @(negedge clk); #2;
         k++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
         sb.delete();
      end
   endtask

   // Waits for a granted request, checks its address, then drops gnt and optionally redirects in the WAIT cycle.
   task automatic wait_grant(input logic [7:0] addr, input logic rd_en, input logic [7:0] rd_pc);
      int k   = 0;
      bit got = 0;
      while (!got && k < 40) begin
         @(negedge clk); #2;
         k++;
         if (im_req && im_gnt) got = 1;
      end
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL grant timeout: no grant, want addr %0h", addr);
      end else begin
         chk("grant addr", {24'h0, im_addr}, {24'h0, addr});
      end
      @(posedge clk); #1;
      im_gnt         = 1'b0;
      redirect_valid = rd_en;
      redirect_pc    = rd_pc;
      if (rd_en) begin
         @(posedge clk); #1;
         redirect_valid = 1'b0;
      end
   endtask

   task automatic fetch_run(input logic [7:0] start, input int n);
      int         k     = 0;
      bit         first = 1;
      bit         done  = 0;
      logic [7:0] last;
      last = start + 8'(n - 1);
      for (int i = 0; i < n; i++) push_exp(start + 8'(i));
      @(posedge clk); #1;
      im_gnt = 1'b1;
      while (!done && k < 20 * n) begin
         @(negedge clk); #2;
         k++;
         if (im_req && im_gnt) begin
            if (first) chk("first fetch addr", {24'h0, im_addr}, {24'h0, start});
            first = 0;
            if (im_addr == last) done = 1;
         end
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL fetch run timeout: last addr not granted, want %0h", last);
      end
      @(posedge clk); #1;
      im_gnt = 1'b0;
      wait_empty(10);
   endtask

   task automatic do_redirect(input logic [7:0] target);
      @(posedge clk); #1;
      redirect_valid = 1'b1;
      redirect_pc    = target;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
   endtask

   // Instruction memory: one response per grant, rv_delay extra cycles after the first.
   initial begin
      logic [7:0] a;
      im_rvalid = 1'b0;
      im_rdata  = '0;
      forever begin
         @(negedge clk);
         if (!rst && im_req && im_gnt) begin
            a = im_addr;
            @(posedge clk);
            repeat (rv_delay) @(posedge clk);
            #1;
            im_rvalid = 1'b1;
            im_rdata  = mem(a);
            @(posedge clk); #1;
            im_rvalid = 1'b0;
            im_rdata  = '0;
         end
      end
   end

   // Monitor: every consumed output must match the head of the scoreboard.
   initial begin
      exp_t       e;
      logic [7:0] p1;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (!if_valid) begin
               chk("inst zero when invalid", {16'h0, if_inst}, 32'h0);
            end else if (id_ready) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected output: pc %0h inst %0h, want none", if_pc, if_inst);
               end else begin
                  e  = sb.pop_front();
                  p1 = e.pc + 8'd1;
                  chk("out pc", {24'h0, if_pc}, {24'h0, e.pc});
                  chk("out inst", {16'h0, if_inst}, {16'h0, e.inst});
                  chk("out pc_plus1", {24'h0, if_pc_plus1}, {24'h0, p1});
                  pop_cyc.push_back(cyc);
               end
            end
         end
      end
   end

   initial begin
      int k;
      rst            = 1'b1;
      im_gnt         = 1'b0;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
      chk("reset if_valid", {31'h0, if_valid}, 32'h0);
      chk("reset if_inst", {16'h0, if_inst}, 32'h0);
      chk("reset if_pc", {24'h0, if_pc}, 32'h0);
      chk("reset im_req", {31'h0, im_req}, 32'h0);

      // Sequential fetch, stalling ID once pc 4 is in flight.
      for (int i = 0; i < 5; i++) push_exp(8'(i));
      @(posedge clk); #1;
      rst    = 1'b0;
      im_gnt = 1'b1;
      k = 0;
      while (sb.size() > 1 && k < 40) begin
         @(negedge clk); #2;
         k++;
      end
      @(posedge clk); #1;
      id_ready = 1'b0;
      k = 0;
      while (!if_valid && k < 10) begin
         @(negedge clk); #2;
         k++;
      end
      repeat (5) begin
         @(negedge clk); #2;
         chk("stall if_valid", {31'h0, if_valid}, 32'h1);
         chk("stall if_pc", {24'h0, if_pc}, 32'h04);
         chk("stall if_inst", {16'h0, if_inst}, 32'h2004);
         chk("stall im_req", {31'h0, im_req}, 32'h0);
      end
      push_exp(8'h05);
      @(posedge clk); #1;
      id_ready = 1'b1;
      @(negedge clk); #2;
      chk("resume im_req", {31'h0, im_req}, 32'h1);
      chk("resume im_addr", {24'h0, im_addr}, 32'h05);
      @(posedge clk); #1;
      im_gnt = 1'b0;
      wait_empty(10);
      if (pop_cyc.size() < 4) begin
         n_cmp++;
         n_err++;
         $display("FAIL fetch count: got %0d outputs, want at least 4", pop_cyc.size());
      end else begin
         for (int i = 0; i < 3; i++)
            chk("fetch spacing", 32'(pop_cyc[i+1] - pop_cyc[i]), 32'd2);
      end

      // Redirect while waiting for data: the 8'h10 response must be swallowed.
      do_redirect(8'h10);
      rv_delay = 1;
      push_exp(8'h40);
      @(posedge clk); #1;
      im_gnt = 1'b1;
      wait_grant(8'h10, 1'b1, 8'h40);
      @(negedge clk); #2;
      chk("drain im_req", {31'h0, im_req}, 32'h0);
      rv_delay = 0;
      @(posedge clk); #1;
      im_gnt = 1'b1;
      wait_grant(8'h40, 1'b0, 8'h00);
      wait_empty(10);

      // Redirect in the same cycle as rvalid: data dropped, next request at target.
      do_redirect(8'h20);
      @(posedge clk); #1;
      im_gnt = 1'b1;
      wait_grant(8'h20, 1'b1, 8'h80);
      @(negedge clk); #2;
      chk("coincident if_valid", {31'h0, if_valid}, 32'h0);
      chk("coincident im_req", {31'h0, im_req}, 32'h1);
      chk("coincident im_addr", {24'h0, im_addr}, 32'h80);
      push_exp(8'h80);
      @(posedge clk); #1;
      im_gnt = 1'b1;
      wait_grant(8'h80, 1'b0, 8'h00);
      wait_empty(10);

      // PC wrap at 8'hFF.
      do_redirect(8'hFF);
      push_exp(8'hFF);
      @(posedge clk); #1;
      im_gnt = 1'b1;
      wait_grant(8'hFF, 1'b0, 8'h00);
      wait_empty(10);
      chk("wrap im_req", {31'h0, im_req}, 32'h1);
      chk("wrap im_addr", {24'h0, im_addr}, 32'h00);

      // Reset while a fetch is outstanding; its late response must be ignored.
      do_redirect(8'h33);
      rv_delay = 3;
      @(posedge clk); #1;
      im_gnt = 1'b1;
      wait_grant(8'h33, 1'b0, 8'h00);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); #2;
      chk("mid reset if_valid", {31'h0, if_valid}, 32'h0);
      chk("mid reset if_inst", {16'h0, if_inst}, 32'h0);
      chk("mid reset if_pc", {24'h0, if_pc}, 32'h0);
      chk("mid reset im_req", {31'h0, im_req}, 32'h0);
      chk("mid reset im_addr", {24'h0, im_addr}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk); #2;
         chk("stale rvalid ignored", {31'h0, if_valid}, 32'h0);
      end
      rv_delay = 0;
      fetch_run(8'h00, 10);

      // Two flushing redirects: one drops a held output, one an in-flight fetch.
      @(posedge clk); #1;
      id_ready = 1'b0;
      im_gnt   = 1'b1;
      wait_grant(8'h0A, 1'b0, 8'h00);
      k = 0;
      while (!if_valid && k < 10) begin
         @(negedge clk); #2;
         k++;
      end
      chk("held pc", {24'h0, if_pc}, 32'h0A);
      chk("held inst", {16'h0, if_inst}, 32'h200A);
      do_redirect(8'h50);
      @(negedge clk); #2;
      chk("flushed if_valid", {31'h0, if_valid}, 32'h0);
      @(posedge clk); #1;
      id_ready = 1'b1;
      rv_delay = 1;
      im_gnt   = 1'b1;
      wait_grant(8'h50, 1'b1, 8'h60);
      repeat (4) begin
         @(negedge clk); #2;
         chk("post flush if_valid", {31'h0, if_valid}, 32'h0);
      end
      @(negedge clk); #2;
      chk("post flush im_addr", {24'h0, im_addr}, 32'h60);
`ifdef IF_PERF_CNT_EN
      chk("perf_fetch_cnt", {16'h0, perf_fetch_cnt}, 32'd10);
      chk("perf_flush_cnt", {16'h0, perf_flush_cnt}, 32'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
